lcd_refresh_scheduler: RTL and testbench

//  Sequences the 16x2 character LCD for the adventure game: runs the power-up init, then streams
//  the 32-char frame from the Rooms logic to the byte-level LCD writer over a req/ack handshake.
//  Re-sends a frame only on change or explicit refresh. Snapshots the frame so the panel never tears.

---
 rtl/lcd_refresh_scheduler.sv | 266 ++++++++++++++++++++++++++
 tb/tb_lcd_refresh_scheduler.sv | 538 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_refresh_scheduler.sv
// -----------------------------------------------------------------------------
// lcd_refresh_scheduler
//   Drives a 16x2 character LCD. After reset it waits out the panel power-up
//   time and sends the init commands 0x38, 0x0C and 0x01. It then waits out the
//   clear time and sends 0x06. From then on it streams the 32-character frame
//   to a byte-level LCD writer: 0x80, line 1, 0xC0, line 2. A frame is
//   re-sent only when the characters change or a refresh is requested. The
//   frame is snapshotted at start so the panel never shows a torn frame.
//
// Ports
//   CLOCK_50    in   1    system clock, rising edge
//   Reset       in   1    synchronous active-low reset
//   characters  in   256  frame, char i at [255-8i -: 8]
//   refresh     in   1    one-cycle pulse forcing a full rewrite
//   wr_req      out  1    byte valid towards the writer
//   wr_rs       out  1    0 = command, 1 = data
//   wr_data     out  8    byte being offered
//   wr_ack      in   1    byte accepted when wr_req && wr_ack
//   busy        out  1    high whenever the scheduler is not idle
//   frame_done  out  1    one-cycle pulse after the last character is accepted
//
// Build option
//   LCD_BLANK_SUB_EN : when defined, data bytes outside 0x20..0x7E are sent as
//                      0x20. Commands and change detection are unaffected.
// -----------------------------------------------------------------------------
module lcd_refresh_scheduler #(
    parameter int POWERUP_CYCLES = 750000,
    parameter int CLEAR_WAIT     = 82000
) (
    input  logic         CLOCK_50,
    input  logic         Reset,
    input  logic [255:0] characters,
    input  logic         refresh,
    output logic         wr_req,
    output logic         wr_rs,
    output logic [7:0]   wr_data,
    input  logic         wr_ack,
    output logic         busy,
    output logic         frame_done
);

    localparam int MAX_WAIT = (POWERUP_CYCLES > CLEAR_WAIT) ? POWERUP_CYCLES : CLEAR_WAIT;
    localparam int WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] PU_LAST   = WAIT_W'(POWERUP_CYCLES - 1);
    localparam logic [WAIT_W-1:0] CW_LAST   = WAIT_W'(CLEAR_WAIT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ZERO = {WAIT_W{1'b0}};
    localparam logic [WAIT_W-1:0] WAIT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_POWERUP = 3'd0,
        ST_INIT    = 3'd1,
        ST_CLRWAIT = 3'd2,
        ST_IDLE    = 3'd3,
        ST_ADDR1   = 3'd4,
        ST_LINE1   = 3'd5,
        ST_ADDR2   = 3'd6,
        ST_LINE2   = 3'd7
    } state_t;

    state_t              r_state, w_state;
    logic [WAIT_W-1:0]   r_wait, w_wait;
    logic [4:0]          r_idx, w_idx;
    logic [255:0]        r_snap, w_snap;
    logic                r_force, w_force;
    logic                r_req, w_req;
    logic                r_rs, w_rs;
    logic [7:0]          r_data, w_data;
    logic                r_busy, w_busy;
    logic                r_frame_done, w_frame_done;
    logic                w_accept;

    // Init command table, indexed by step 0..2.
    function automatic logic [7:0] init_cmd(input logic [1:0] step);
        case (step)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            default: return 8'h01;
        endcase
    endfunction

    // Extract character idx from a frame (char 0 sits in the top byte).
    function automatic logic [7:0] char_at(input logic [255:0] frame, input logic [4:0] idx);
        logic [4:0] inv;
        inv = 5'd31 - idx;
        return frame[{inv, 3'b000} +: 8];
    endfunction

    // Data byte as presented on the bus.
    function automatic logic [7:0] data_byte(input logic [7:0] c);
`ifdef LCD_BLANK_SUB_EN
        if ((c < 8'h20) || (c > 8'h7E)) begin
            return 8'h20;
        end else begin
            return c;
        end
`else
        return c;
`endif
    endfunction

    // Next-state and next-output logic.
    always_comb begin
        w_state      = r_state;
        w_wait       = r_wait;
        w_idx        = r_idx;
        w_snap       = r_snap;
        w_force      = r_force | refresh;   // refresh while busy is held for the next IDLE
        w_req        = r_req;
        w_rs         = r_rs;
        w_data       = r_data;
        w_frame_done = 1'b0;
        w_accept     = r_req & wr_ack;

        case (r_state)
            ST_POWERUP: begin
                if (r_wait >= PU_LAST) begin
                    w_state = ST_INIT;
                    w_wait  = WAIT_ZERO;
                    w_idx   = 5'd0;
                    w_req   = 1'b1;
                    w_rs    = 1'b0;
                    w_data  = init_cmd(2'd0);
                end else begin
                    w_wait  = r_wait + WAIT_ONE;
                end
            end
            ST_INIT: begin
                if (w_accept) begin
                    if (r_idx >= 5'd2) begin
                        w_state = ST_CLRWAIT;
                        w_wait  = WAIT_ZERO;
                        w_req   = 1'b0;
                    end else begin
                        w_idx   = r_idx + 5'd1;
                        w_data  = init_cmd(r_idx[1:0] + 2'd1);
                    end
                end else begin
                    w_idx = r_idx;
                end
            end
            ST_CLRWAIT: begin
                // First count the clear time, then offer 0x06 within this state.
                if (r_req) begin
                    if (wr_ack) begin
                        w_state = ST_IDLE;
                        w_req   = 1'b0;
                    end else begin
                        w_req   = 1'b1;
                    end
                end else if (r_wait >= CW_LAST) begin
                    w_req  = 1'b1;
                    w_rs   = 1'b0;
                    w_data = 8'h06;
                end else begin
                    w_wait = r_wait + WAIT_ONE;
                end
            end
            ST_IDLE: begin
                if (r_force || refresh || (characters != r_snap)) begin
                    w_snap  = characters;
                    w_force = 1'b0;
                    w_state = ST_ADDR1;
                    w_req   = 1'b1;
                    w_rs    = 1'b0;
                    w_data  = 8'h80;
                end else begin
                    w_force = r_force;
                end
            end
            ST_ADDR1: begin
                if (w_accept) begin
                    w_state = ST_LINE1;
                    w_idx   = 5'd0;
                    w_rs    = 1'b1;
                    w_data  = data_byte(char_at(r_snap, 5'd0));
                end else begin
                    w_idx = r_idx;
                end
            end
            ST_LINE1: begin
                if (w_accept) begin
                    if (r_idx == 5'd15) begin
                        w_state = ST_ADDR2;
                        w_rs    = 1'b0;
                        w_data  = 8'hC0;
                    end else begin
                        w_idx   = r_idx + 5'd1;
                        w_data  = data_byte(char_at(r_snap, r_idx + 5'd1));
                    end
                end else begin
                    w_idx = r_idx;
                end
            end
            ST_ADDR2: begin
                if (w_accept) begin
                    w_state = ST_LINE2;
                    w_idx   = 5'd16;
                    w_rs    = 1'b1;
                    w_data  = data_byte(char_at(r_snap, 5'd16));
                end else begin
                    w_idx = r_idx;
                end
            end
            ST_LINE2: begin
                if (w_accept) begin
                    if (r_idx == 5'd31) begin
                        w_state      = ST_IDLE;
                        w_req        = 1'b0;
                        w_rs         = 1'b0;
                        w_frame_done = 1'b1;
                    end else begin
                        w_idx   = r_idx + 5'd1;
                        w_data  = data_byte(char_at(r_snap, r_idx + 5'd1));
                    end
                end else begin
                    w_idx = r_idx;
                end
            end
            default: begin
                w_state = ST_POWERUP;
                w_wait  = WAIT_ZERO;
                w_idx   = 5'd0;
                w_force = 1'b1;
                w_req   = 1'b0;
                w_rs    = 1'b0;
                w_data  = 8'h00;
            end
        endcase

        w_busy = (w_state != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLOCK_50) begin
        if (!Reset) begin
            r_state      <= ST_POWERUP;
            r_wait       <= WAIT_ZERO;
            r_idx        <= 5'd0;
            r_snap       <= 256'd0;
            r_force      <= 1'b1;
            r_req        <= 1'b0;
            r_rs         <= 1'b0;
            r_data       <= 8'h00;
            r_busy       <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_wait       <= w_wait;
            r_idx        <= w_idx;
            r_snap       <= w_snap;
            r_force      <= w_force;
            r_req        <= w_req;
            r_rs         <= w_rs;
            r_data       <= w_data;
            r_busy       <= w_busy;
            r_frame_done <= w_frame_done;
        end
    end

    assign wr_req     = r_req;
    assign wr_rs      = r_rs;
    assign wr_data    = r_data;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_lcd_refresh_scheduler.sv
// -----------------------------------------------------------------------------
// tb_lcd_refresh_scheduler
//   Bench for lcd_refresh_scheduler with short wait times. A writer model acks
//   one cycle after it sees wr_req and logs every accepted byte with its cycle
//   number. Expected byte streams come from a frame model: 0x80, 16 chars,
//   0xC0, 16 chars.
// -----------------------------------------------------------------------------
module tb_lcd_refresh_scheduler;

    localparam int PU = 8;
    localparam int CW = 4;

    logic         clk;
    logic         rst;
    logic [255:0] chars;
    logic         refresh;
    logic         wr_req;
    logic         wr_rs;
    logic [7:0]   wr_data;
    logic         ack;
    logic         busy;
    logic         frame_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit ack_en   = 1'b1;
    logic prev_req = 1'b0;
    int overlap_cnt = 0;

    logic [8:0] q_byte[$];
    int         q_cyc[$];
    int         fd_cyc[$];

    lcd_refresh_scheduler #(
        .POWERUP_CYCLES(PU),
        .CLEAR_WAIT    (CW)
    ) dut (
        .CLOCK_50  (clk),
        .Reset     (rst),
        .characters(chars),
        .refresh   (refresh),
        .wr_req    (wr_req),
        .wr_rs     (wr_rs),
        .wr_data   (wr_data),
        .wr_ack    (ack),
        .busy      (busy),
        .frame_done(frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Writer model: ack follows wr_req with one cycle of delay; log accepts.
    initial begin
        ack = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            ack = ack_en && prev_req;
            prev_req = wr_req;
            if (wr_req && ack) begin
                q_byte.push_back({wr_rs, wr_data});
                q_cyc.push_back(cyc);
            end
            if (frame_done) begin
                fd_cyc.push_back(cyc);
                if (wr_req) overlap_cnt++;
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] exp_sub(input logic [7:0] c);
`ifdef LCD_BLANK_SUB_EN
        return ((c < 8'h20) || (c > 8'h7E)) ? 8'h20 : c;
`else
        return c;
`endif
    endfunction

    // Byte k (0..33) of the bus stream that writes frame f.
    function automatic logic [8:0] frame_byte(input logic [255:0] f, input int k);
        int i;
        if (k == 0)  return {1'b0, 8'h80};
        if (k == 17) return {1'b0, 8'hC0};
        i = (k < 17) ? (k - 1) : (k - 2);
        return {1'b1, exp_sub(f[8*(31-i) +: 8])};
    endfunction

    function automatic logic [255:0] text_frame(input string s);
        logic [255:0] f;
        logic [7:0]   b;
        f = 256'd0;
        for (int i = 0; i < 32; i++) begin
            b = (i < s.len()) ? 8'(s[i]) : 8'h20;
            f = {f[247:0], b};
        end
        return f;
    endfunction

    function automatic logic [255:0] set_char(input logic [255:0] f, input int i, input logic [7:0] c);
        logic [255:0] g;
        g = f;
        g[8*(31-i) +: 8] = c;
        return g;
    endfunction

    function automatic logic [255:0] rand_frame();
        logic [255:0] f;
        for (int i = 0; i < 8; i++) f[32*i +: 32] = $urandom;
        return f;
    endfunction

    // ---------------- utilities ----------------
    task automatic clear_log();
        q_byte.delete();
        q_cyc.delete();
        fd_cyc.delete();
    endtask

    task automatic wait_bytes(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (q_byte.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bit bad;
        rst = 1'b0;
        refresh = 1'b0;
        ack_en = 1'b1;
        chars = text_frame("NORTH ROOM");
        clear_log();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({wr_req, busy, frame_done, wr_rs, wr_data} !== {1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_state: got req/busy/fd/rs/data=%b%b%b%b/%h expected 0110/00",
                     wr_req, busy, frame_done, wr_rs, wr_data);
        end
        rst = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < PU; i++) begin
            if (i > 0) @(negedge clk);
            if (wr_req !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL powerup_quiet: got wr_req high within %0d cycles expected low", PU);
        end
        @(negedge clk);
        n_checks++;
        if ({wr_req, wr_rs, wr_data} !== {1'b1, 1'b0, 8'h38}) begin
            n_fail++;
            $display("FAIL first_cmd: got req/rs/data=%b/%b/%h expected 1/0/38", wr_req, wr_rs, wr_data);
        end
    endtask

    task automatic test_init();
        bit ok;
        logic [8:0] exp_init[4];
        exp_init[0] = {1'b0, 8'h38};
        exp_init[1] = {1'b0, 8'h0C};
        exp_init[2] = {1'b0, 8'h01};
        exp_init[3] = {1'b0, 8'h06};
        wait_bytes(4, 200, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL init_timeout: got %0d bytes expected 4", q_byte.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (q_byte[k] !== exp_init[k]) begin
                    n_fail++;
                    $display("FAIL init_byte%0d: got %h expected %h", k, q_byte[k], exp_init[k]);
                end
            end
            n_checks++;
            if ((q_cyc[1] - q_cyc[0] != 1) || (q_cyc[2] - q_cyc[1] != 1)) begin
                n_fail++;
                $display("FAIL init_b2b: got gaps %0d %0d expected 1 1",
                         q_cyc[1] - q_cyc[0], q_cyc[2] - q_cyc[1]);
            end
            // accept cycle + CW quiet cycles + one cycle of writer ack latency
            n_checks++;
            if (q_cyc[3] - q_cyc[2] != CW + 2) begin
                n_fail++;
                $display("FAIL clear_wait: got gap %0d expected %0d", q_cyc[3] - q_cyc[2], CW + 2);
            end
        end
    endtask

    task automatic test_first_frame();
        bit ok;
        bit bad;
        logic [255:0] f;
        f = text_frame("NORTH ROOM");
        wait_bytes(38, 400, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL frame1_timeout: got %0d bytes expected 38", q_byte.size());
        end else begin
            for (int k = 0; k < 34; k++) begin
                n_checks++;
                if (q_byte[4+k] !== frame_byte(f, k)) begin
                    n_fail++;
                    $display("FAIL frame1_byte%0d: got %h expected %h", k, q_byte[4+k], frame_byte(f, k));
                end
            end
            bad = 1'b0;
            for (int k = 0; k < 33; k++) if (q_cyc[5+k] - q_cyc[4+k] != 1) bad = 1'b1;
            n_checks++;
            if (bad) begin
                n_fail++;
                $display("FAIL frame1_b2b: got a gap inside the frame expected 1 byte/cycle");
            end
            n_checks++;
            if (q_cyc[4] - q_cyc[3] != 3) begin
                n_fail++;
                $display("FAIL idle_to_addr: got gap %0d expected 3", q_cyc[4] - q_cyc[3]);
            end
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (fd_cyc.size() != 1 || (ok && fd_cyc[0] != q_cyc[37] + 1)) begin
            n_fail++;
            $display("FAIL frame_done_pulse: got %0d pulses expected 1 right after the last byte",
                     fd_cyc.size());
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_busy: got %b expected 0", busy);
        end
        repeat (30) @(negedge clk);
        n_checks++;
        if (q_byte.size() != 38 || fd_cyc.size() != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL held_frame_quiet: got %0d bytes %0d pulses busy %b expected 38 1 0",
                     q_byte.size(), fd_cyc.size(), busy);
        end
    endtask

    task automatic test_random_frames();
        bit ok;
        logic [255:0] f;
        for (int it = 0; it < 4; it++) begin
            clear_log();
            f = rand_frame();
            chars = f;
            wait_bytes(34, 200, ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL rand%0d_timeout: got %0d bytes expected 34", it, q_byte.size());
            end else begin
                for (int k = 0; k < 34; k++) begin
                    n_checks++;
                    if (q_byte[k] !== frame_byte(f, k)) begin
                        n_fail++;
                        $display("FAIL rand%0d_byte%0d: got %h expected %h", it, k, q_byte[k], frame_byte(f, k));
                    end
                end
            end
            repeat (8) @(negedge clk);
            n_checks++;
            if (q_byte.size() != 34 || fd_cyc.size() != 1) begin
                n_fail++;
                $display("FAIL rand%0d_count: got %0d bytes %0d pulses expected 34 1",
                         it, q_byte.size(), fd_cyc.size());
            end
        end
    endtask

    task automatic test_change_in_flight();
        bit ok;
        logic [255:0] f_old;
        logic [255:0] f_new;
        clear_log();
        f_old = text_frame("CAVE ENTRANCE   DARK PASSAGE");
        f_new = set_char(f_old, 20, 8'h53);
        chars = f_old;
        wait_bytes(6, 100, ok);
        chars = f_new;
        wait_bytes(68, 400, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL change_timeout: got %0d bytes expected 68", q_byte.size());
        end else begin
            for (int k = 0; k < 34; k++) begin
                n_checks++;
                if (q_byte[k] !== frame_byte(f_old, k)) begin
                    n_fail++;
                    $display("FAIL inflight_byte%0d: got %h expected %h", k, q_byte[k], frame_byte(f_old, k));
                end
                n_checks++;
                if (q_byte[34+k] !== frame_byte(f_new, k)) begin
                    n_fail++;
                    $display("FAIL second_byte%0d: got %h expected %h", k, q_byte[34+k], frame_byte(f_new, k));
                end
            end
            n_checks++;
            if (q_byte[34+22] !== {1'b1, 8'h53}) begin
                n_fail++;
                $display("FAIL char20_S: got %h expected 153", q_byte[34+22]);
            end
            n_checks++;
            if (q_cyc[34] - q_cyc[33] != 3) begin
                n_fail++;
                $display("FAIL restart_gap: got %0d expected 3", q_cyc[34] - q_cyc[33]);
            end
        end
        repeat (6) @(negedge clk);
        n_checks++;
        if (fd_cyc.size() != 2 || overlap_cnt != 0) begin
            n_fail++;
            $display("FAIL change_pulses: got %0d pulses %0d overlaps expected 2 0", fd_cyc.size(), overlap_cnt);
        end
    endtask

    task automatic test_refresh();
        bit ok;
        logic [255:0] f;
        clear_log();
        f = chars;
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
        wait_bytes(34, 200, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL refresh_timeout: got %0d bytes expected 34", q_byte.size());
        end else begin
            for (int k = 0; k < 34; k++) begin
                n_checks++;
                if (q_byte[k] !== frame_byte(f, k)) begin
                    n_fail++;
                    $display("FAIL refresh_byte%0d: got %h expected %h", k, q_byte[k], frame_byte(f, k));
                end
            end
        end
        repeat (20) @(negedge clk);
        n_checks++;
        if (q_byte.size() != 34) begin
            n_fail++;
            $display("FAIL refresh_once: got %0d bytes expected 34", q_byte.size());
        end
        // refresh while busy: one extra identical frame afterwards
        clear_log();
        f = rand_frame();
        chars = f;
        wait_bytes(3, 100, ok);
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
        wait_bytes(68, 400, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL busy_refresh_timeout: got %0d bytes expected 68", q_byte.size());
        end else begin
            for (int k = 0; k < 68; k++) begin
                n_checks++;
                if (q_byte[k] !== frame_byte(f, k % 34)) begin
                    n_fail++;
                    $display("FAIL busy_refresh_byte%0d: got %h expected %h", k, q_byte[k], frame_byte(f, k % 34));
                end
            end
        end
        repeat (20) @(negedge clk);
        n_checks++;
        if (q_byte.size() != 68) begin
            n_fail++;
            $display("FAIL busy_refresh_count: got %0d bytes expected 68", q_byte.size());
        end
    endtask

    task automatic test_ack_hold_and_reset();
        bit ok;
        bit bad;
        logic [255:0] f;
        clear_log();
        ack_en = 1'b0;
        f = text_frame("LOCKED DOOR");
        chars = f;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (wr_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL hold_req_timeout: got wr_req %b expected 1", wr_req);
        end
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ({wr_req, wr_rs, wr_data} !== {1'b1, 1'b0, 8'h80}) bad = 1'b1;
        end
        n_checks++;
        if (bad || q_byte.size() != 0) begin
            n_fail++;
            $display("FAIL hold_stable: got req/rs/data=%b/%b/%h expected 1/0/80 throughout", wr_req, wr_rs, wr_data);
        end
        ack_en = 1'b1;
        wait_bytes(34, 200, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL hold_frame_timeout: got %0d bytes expected 34", q_byte.size());
        end else begin
            for (int k = 0; k < 34; k++) begin
                n_checks++;
                if (q_byte[k] !== frame_byte(f, k)) begin
                    n_fail++;
                    $display("FAIL hold_byte%0d: got %h expected %h", k, q_byte[k], frame_byte(f, k));
                end
            end
        end
        repeat (4) @(negedge clk);
        // reset in the middle of line 2
        clear_log();
        f = text_frame("TREASURE HALL   GOLD EVERYWHERE!");
        chars = f;
        wait_bytes(22, 100, ok);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({wr_req, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL midreset: got req/busy=%b%b expected 01", wr_req, busy);
        end
        clear_log();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wait_bytes(38, 400, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL reinit_timeout: got %0d bytes expected 38", q_byte.size());
        end else begin
            n_checks++;
            if ({q_byte[0], q_byte[1], q_byte[2], q_byte[3]} !==
                {9'h038, 9'h00C, 9'h001, 9'h006}) begin
                n_fail++;
                $display("FAIL reinit_cmds: got %h %h %h %h expected 038 00c 001 006",
                         q_byte[0], q_byte[1], q_byte[2], q_byte[3]);
            end
            for (int k = 0; k < 34; k++) begin
                n_checks++;
                if (q_byte[4+k] !== frame_byte(f, k)) begin
                    n_fail++;
                    $display("FAIL reinit_byte%0d: got %h expected %h", k, q_byte[4+k], frame_byte(f, k));
                end
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_blank_sub();
        bit ok;
        logic [255:0] f;
        logic [8:0]   exp0;
`ifdef LCD_BLANK_SUB_EN
        exp0 = {1'b1, 8'h20};
`else
        exp0 = {1'b1, 8'h07};
`endif
        clear_log();
        f = text_frame("XYZW EXIT");
        f = set_char(f, 0, 8'h07);
        f = set_char(f, 1, 8'h7F);
        f = set_char(f, 2, 8'h7E);
        f = set_char(f, 3, 8'h1F);
        f = set_char(f, 31, 8'hFF);
        chars = f;
        wait_bytes(34, 200, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL blank_timeout: got %0d bytes expected 34", q_byte.size());
        end else begin
            n_checks++;
            if (q_byte[1] !== exp0) begin
                n_fail++;
                $display("FAIL blank_char0: got %h expected %h", q_byte[1], exp0);
            end
            n_checks++;
            if (q_byte[3] !== {1'b1, 8'h7E}) begin
                n_fail++;
                $display("FAIL blank_7e: got %h expected 17e", q_byte[3]);
            end
            for (int k = 0; k < 34; k++) begin
                n_checks++;
                if (q_byte[k] !== frame_byte(f, k)) begin
                    n_fail++;
                    $display("FAIL blank_byte%0d: got %h expected %h", k, q_byte[k], frame_byte(f, k));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        refresh = 1'b0;
        chars = 256'd0;
        test_reset();
        test_init();
        test_first_frame();
        test_random_frames();
        test_change_in_flight();
        test_refresh();
        test_ack_hold_and_reset();
        test_blank_sub();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
